ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//  Consumes bytes from the PS/2 byte receiver (8-bit data + 1-cycle strobe), tracks PS/2 set-2 prefixes (E0/F0)
//  and converts key make codes into uppercase ASCII characters.
//  Presents the characters to the downstream Morse encoder over a valid/ready handshake.
//  Break codes, unmapped keys and keyboard status bytes are swallowed.
// PARAMETERS
//  FIFO_DEPTH   4   character buffer depth when PS2_DECODER_FIFO_EN defined; power of 2, >=2; ignored otherwise
// PORTS
//  clk                     in   1  system clock
//  rst                     in   1  synchronous, active-high reset
//  ps2_received_data       in   8  received PS/2 byte, valid when strobe high
//  ps2_received_data_strb  in   1  1-cycle pulse per received byte
//  char_ready              in   1  downstream accepts char this cycle
//  char_data               out  8  ASCII character (uppercase A-Z, 0-9, 0x20, 0x0D)
//  char_valid              out  1  char_data valid; held until char_valid && char_ready
//  char_overflow           out  1  1-cycle pulse: decoded char dropped because buffer full
// BEHAVIOUR
//  Reset: char_data=8'h00, char_valid=0, char_overflow=0, FSM=IDLE, buffer empty.
//  Reset mid-sequence (e.g. after F0) discards the prefix and all buffered chars.
//  Prefix FSM (advances only on strobe):
//   - IDLE: F0->BREAK; E0->EXT; mapped make code->emit, stay IDLE; any other byte (AA, FA, EE, FE, E1, ...)->ignore, stay IDLE.
//   - BREAK: any byte->IDLE, no emit.
//   - EXT: F0->EXT_BREAK; 5A->emit 0x0D, IDLE; E0->stay EXT; other->IDLE, no emit.
//   - EXT_BREAK: any byte->IDLE, no emit.
//   - Illegal state encoding->IDLE.
//  Map (make->ASCII), letters:
//   1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M,
//   31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
//  Map, digits and others:
//   45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9; 29 space (0x20), 5A enter (0x0D).
//  Typematic repeats of a held key are make codes and each emits a char.
//  Latency: strobe in cycle N with empty buffer -> char_valid=1 in cycle N+1 (registered).
//  Handshake: transfer on char_valid && char_ready. char_data is stable while char_valid=1 and char_ready=0.
//  Push and pop in the same cycle are both honoured, including when the buffer is full.
//  Push into a full buffer with no pop: char dropped, char_overflow=1 in cycle N+1, buffered contents unchanged.
// CONFIGURATION
//  PS2_DECODER_FIFO_EN defined:
//   - FIFO_DEPTH-entry circular buffer.
//   - char_valid = !empty; char_data = head entry.
//   - Pointers are log2(FIFO_DEPTH)+1 bits, wrapping naturally; full/empty from MSB compare.
//  PS2_DECODER_FIFO_EN undefined:
//   - Single holding register (depth 1); full == char_valid.
//   - FIFO_DEPTH unused; identical port list and timing.
// STRUCTURE
//  ps2_pkg holds:
//   - scancode constants: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_ENTER=8'h5A
//   - ASCII constants: ASCII_CR=8'h0D, ASCII_SPACE=8'h20
//   - FSM state localparams: 2-bit DEC_IDLE/DEC_BREAK/DEC_EXT/DEC_EXT_BREAK
//  Scancode->ASCII lookup is a combinational function in ps2_pkg returning {hit, ascii}.
//  Sub-module ps2_char_fifo (DEPTH param, push/pop/full/empty/head) is instantiated only under PS2_DECODER_FIFO_EN.
// TESTING
//  1. Strobe 1C, char_ready=1 -> char_valid=1 with char_data=8'h41 one cycle later, for exactly one cycle.
//  2. Strobe F0,1C then 1C -> no output for F0,1C; single 0x41 for the second 1C.
//  3. Strobe E0,5A -> 0x0D emitted. E0,F0,5A -> nothing. E0,75 -> nothing; next 16 emits 0x31.
//  4. char_ready=0, send 1C,32,21,23,24:
//     - FIFO_EN: first 4 buffered, 5th (0x45) pulses char_overflow; release ready -> A,B,C,D in order.
//     - No FIFO: 0x41 held, 4 overflow pulses.
//  5. Full buffer, strobe 29 in the same cycle as char_ready=1 -> no overflow; 0x20 emitted last.
//  6. Strobe F0, assert rst 1 cycle, strobe 1C -> 0x41 emitted (prefix cleared); rst with chars buffered -> char_valid=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, prefix-tracker states and the
// scancode-to-ASCII lookup used by the scancode decoder.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    DEC_IDLE      = 2'd0,
    DEC_BREAK     = 2'd1,
    DEC_EXT       = 2'd2,
    DEC_EXT_BREAK = 2'd3
  } dec_state_e;

  // Returns {hit, ascii}; hit=0 for keys with no character.
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] sc);
    logic [7:0] a;
    logic       hit;
    hit = 1'b1;
    a   = 8'h00;
    case (sc)
      8'h1C: a = 8'h41;
      8'h32: a = 8'h42;
      8'h21: a = 8'h43;
      8'h23: a = 8'h44;
      8'h24: a = 8'h45;
      8'h2B: a = 8'h46;
      8'h34: a = 8'h47;
      8'h33: a = 8'h48;
      8'h43: a = 8'h49;
      8'h3B: a = 8'h4A;
      8'h42: a = 8'h4B;
      8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D;
      8'h31: a = 8'h4E;
      8'h44: a = 8'h4F;
      8'h4D: a = 8'h50;
      8'h15: a = 8'h51;
      8'h2D: a = 8'h52;
      8'h1B: a = 8'h53;
      8'h2C: a = 8'h54;
      8'h3C: a = 8'h55;
      8'h2A: a = 8'h56;
      8'h1D: a = 8'h57;
      8'h22: a = 8'h58;
      8'h35: a = 8'h59;
      8'h1A: a = 8'h5A;
      8'h45: a = 8'h30;
      8'h16: a = 8'h31;
      8'h1E: a = 8'h32;
      8'h26: a = 8'h33;
      8'h25: a = 8'h34;
      8'h2E: a = 8'h35;
      8'h36: a = 8'h36;
      8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;
      8'h46: a = 8'h39;
      8'h29: a = ASCII_SPACE;
      SC_ENTER: a = ASCII_CR;
      default: hit = 1'b0;
    endcase
    return {hit, a};
  endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// Small circular character buffer; pointers carry one extra
// wrap bit so full and empty are told apart by the MSB.
module ps2_char_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        wr_en, rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // A full buffer still accepts a write when the head leaves this cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (wr_en) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + 1'b1;
    end
    if (rd_en) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 make codes to uppercase ASCII over valid/ready.
// Define PS2_DECODER_FIFO_EN for a FIFO_DEPTH-entry buffer.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  input  logic       char_ready,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       char_overflow
);

  dec_state_e state_q, state_d;
  logic [8:0] lut;
  logic       push;
  logic [7:0] push_char;
  logic       pop;
  logic       full;
  logic       ovf_q, ovf_d;

  assign lut = sc_to_ascii(ps2_received_data);

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_char = lut[7:0];
    if (ps2_received_data_strb) begin
      unique case (state_q)
        DEC_IDLE: begin
          if (ps2_received_data == SC_BREAK) begin
            state_d = DEC_BREAK;
          end else if (ps2_received_data == SC_EXT) begin
            state_d = DEC_EXT;
          end else begin
            push = lut[8];
          end
        end
        DEC_EXT: begin
          if (ps2_received_data == SC_BREAK) begin
            state_d = DEC_EXT_BREAK;
          end else if (ps2_received_data == SC_ENTER) begin
            state_d   = DEC_IDLE;
            push      = 1'b1;
            push_char = ASCII_CR;
          end else if (ps2_received_data != SC_EXT) begin
            state_d = DEC_IDLE;
          end
        end
        default: state_d = DEC_IDLE;
      endcase
    end
  end

  assign pop   = char_valid && char_ready;
  assign ovf_d = push && full && !pop;
  assign char_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEC_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef PS2_DECODER_FIFO_EN
  logic empty;

  ps2_char_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (push_char),
    .full (full),
    .empty(empty),
    .head (char_data)
  );

  assign char_valid = !empty;
`else
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       unused_depth;

  assign unused_depth = FIFO_DEPTH[0];
  assign full       = valid_q;
  assign char_valid = valid_q;
  assign char_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (push && (!full || pop)) begin
      valid_d = 1'b1;
      data_d  = push_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: queue-based model compared
// every cycle plus directed literal checks.
module tb_ps2_scancode_decoder;

`ifdef PS2_DECODER_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       strb = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_overflow;

  ps2_scancode_decoder #(
    .FIFO_DEPTH(4)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ps2_received_data     (din),
    .ps2_received_data_strb(strb),
    .char_ready            (ready),
    .char_data             (char_data),
    .char_valid            (char_valid),
    .char_overflow         (char_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: key tables, pending-prefix flags, character queue.
  byte unsigned letters[26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digits[10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
    8'h46};

  function automatic int lookup(input byte unsigned sc);
    for (int i = 0; i < 26; i++) if (letters[i] == sc) return 65 + i;
    for (int i = 0; i < 10; i++) if (digits[i] == sc) return 48 + i;
    if (sc == 8'h29) return 32;
    if (sc == 8'h5A) return 13;
    return -1;
  endfunction

  byte unsigned q[$];
  bit m_swallow = 0;
  bit m_ext = 0;
  bit m_ovf = 0;
  bit started = 0;
  int ch;
  bit m_pop;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_swallow = 0;
      m_ext = 0;
      m_ovf = 0;
      started = 1;
    end else begin
      ch = -1;
      m_pop = (q.size() > 0) && ready;
      if (strb) begin
        if (m_swallow) begin
          m_swallow = 0;
        end else if (m_ext) begin
          if (din == 8'hF0) begin
            m_swallow = 1;
            m_ext = 0;
          end else if (din == 8'h5A) begin
            ch = 13;
            m_ext = 0;
          end else if (din != 8'hE0) begin
            m_ext = 0;
          end
        end else if (din == 8'hF0) begin
          m_swallow = 1;
        end else if (din == 8'hE0) begin
          m_ext = 1;
        end else begin
          ch = lookup(din);
        end
      end
      if (m_pop) void'(q.pop_front());
      m_ovf = 0;
      if (ch >= 0) begin
        if (q.size() < CAP) q.push_back(byte'(ch));
        else m_ovf = 1;
      end
    end
  end

  byte unsigned got[$];
  int ovf_seen = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("valid", char_valid, q.size() != 0);
      if (q.size() != 0) chk("data", char_data, q[0]);
      chk("overflow", char_overflow, m_ovf);
      if (char_valid && ready) got.push_back(char_data);
      if (char_overflow) ovf_seen++;
    end
  end

  task automatic step(input logic s, input logic [7:0] d,
                      input logic r);
    strb  = s;
    din   = d;
    ready = r;
    @(posedge clk);
    #1;
    strb = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", char_valid, 1'b0);
    chk("rst_data", char_data, 8'h00);
    chk("rst_ovf", char_overflow, 1'b0);
    rst = 1'b0;

    // single make code, one-cycle valid
    step(1, 8'h1C, 1);
    chk("t1_valid", char_valid, 1'b1);
    chk("t1_data", char_data, 8'h41);
    step(0, 8'h00, 1);
    chk("t1_gone", char_valid, 1'b0);

    // break code swallowed
    got.delete();
    step(1, 8'hF0, 1);
    step(1, 8'h1C, 1);
    step(1, 8'h1C, 1);
    step(0, 8'h00, 1);
    chk("t2_count", got.size(), 1);
    if (got.size() > 0) chk("t2_char", got[0], 8'h41);

    // extended prefixes
    got.delete();
    step(1, 8'hE0, 1);
    step(1, 8'h5A, 1);
    step(0, 8'h00, 1);
    chk("t3_enter_n", got.size(), 1);
    if (got.size() > 0) chk("t3_enter", got[0], 8'h0D);
    got.delete();
    step(1, 8'hE0, 1);
    step(1, 8'hF0, 1);
    step(1, 8'h5A, 1);
    step(0, 8'h00, 1);
    chk("t3_extbrk", got.size(), 0);
    step(1, 8'hE0, 1);
    step(1, 8'h75, 1);
    step(1, 8'h16, 1);
    step(0, 8'h00, 1);
    chk("t3_after_n", got.size(), 1);
    if (got.size() > 0) chk("t3_after", got[0], 8'h31);

    // fill with ready low, then drain
    got.delete();
    ovf_seen = 0;
    step(1, 8'h1C, 0);
    step(1, 8'h32, 0);
    step(1, 8'h21, 0);
    step(1, 8'h23, 0);
    step(1, 8'h24, 0);
    step(0, 8'h00, 0);
    chk("t4_ovf_n", ovf_seen, (CAP == 4) ? 1 : 4);
    chk("t4_hold", char_data, 8'h41);
    repeat (6) step(0, 8'h00, 1);
    chk("t4_drain_n", got.size(), CAP);
    for (int i = 0; i < CAP && i < got.size(); i++)
      chk("t4_order", got[i], 8'h41 + i);

    // push and pop together while full
    for (int i = 0; i < CAP; i++) step(1, letters[i], 0);
    chk("t5_full", char_valid, 1'b1);
    got.delete();
    ovf_seen = 0;
    step(1, 8'h29, 1);
    repeat (CAP + 2) step(0, 8'h00, 1);
    chk("t5_ovf", ovf_seen, 0);
    chk("t5_n", got.size(), CAP + 1);
    if (got.size() > 0) chk("t5_last", got[got.size() - 1], 8'h20);

    // reset clears prefix and buffered chars
    step(1, 8'hF0, 1);
    rst = 1'b1;
    step(0, 8'h00, 1);
    rst = 1'b0;
    got.delete();
    step(1, 8'h1C, 1);
    step(0, 8'h00, 1);
    chk("t6_prefix_n", got.size(), 1);
    if (got.size() > 0) chk("t6_prefix", got[0], 8'h41);
    for (int i = 0; i < CAP; i++) step(1, digits[i], 0);
    chk("t6_loaded", char_valid, 1'b1);
    rst = 1'b1;
    step(0, 8'h00, 0);
    rst = 1'b0;
    chk("t6_valid", char_valid, 1'b0);
    chk("t6_data", char_data, 8'h00);
    step(0, 8'h00, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
